// File: rtl/imem_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit instruction words,
// writes them from address 0 and holds the core in reset until the checksum verifies.
module imem_loader #(
    parameter int INST_MEM_DEPTH = 256,
    parameter int width          = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [15:0]        word_count,
    input  logic               s_valid,
    input  logic [width-1:0]   s_data,
    output logic               s_ready,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [4*width-1:0] mem_wd,
    output logic               cpu_rst,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int MAX_WORDS = INST_MEM_DEPTH / 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t state, state_nx;

    logic [15:0]        wc_q;
    logic [15:0]        word_idx;
    logic [1:0]         byte_idx;
    logic [width-1:0]   csum;
    logic [4*width-1:0] asm_q;

    logic hs;
    logic count_ok;
    logic last_byte;
    logic last_word;
    logic load_go;

    assign hs        = s_valid && s_ready;
    assign count_ok  = (word_count != 16'd0) &&
                       (32'(word_count) <= 32'(MAX_WORDS));
    assign last_byte = (byte_idx == 2'd3);
    assign last_word = (word_idx == wc_q - 16'd1);
    assign load_go   = (state_nx == LOAD) && (state != LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        s_ready  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_rst  = 1'b1;
        unique case (state)
            IDLE, DONE, ERROR: begin
                done    = (state == DONE);
                error   = (state == ERROR);
                cpu_rst = (state != DONE);
                if (start) begin
                    state_nx = count_ok ? LOAD : ERROR;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (hs && last_byte && last_word) begin
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (hs) begin
                    state_nx = (s_data == csum) ? DONE : ERROR;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The write strobe is registered, so it lands the cycle after the 4th byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            wc_q     <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            csum     <= '0;
            asm_q    <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_wd   <= '0;
        end else begin
            mem_we <= 1'b0;
            if (load_go) begin
                wc_q     <= word_count;
                word_idx <= '0;
                byte_idx <= '0;
                csum     <= '0;
            end else if (state == LOAD && hs) begin
                asm_q    <= {asm_q[3*width-1:0], s_data};
                csum     <= csum ^ s_data;
                byte_idx <= byte_idx + 2'd1;
                if (last_byte) begin
                    mem_we   <= 1'b1;
                    mem_addr <= 32'({word_idx, 2'b00});
                    mem_wd   <= {asm_q[3*width-1:0], s_data};
                    word_idx <= word_idx + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed/randomised bench for imem_loader against a word-list reference model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] word_count;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    imem_loader #(
        .INST_MEM_DEPTH(256),
        .width(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .word_count(word_count),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wd(mem_wd),
        .cpu_rst(cpu_rst),
        .busy(busy),
        .done(done),
        .error(error)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        writes[$];
    logic [7:0] stream[$];

    always @(posedge clk) begin
        wr_t w;
        #1;
        if (mem_we === 1'b1) begin
            w.addr = mem_addr;
            w.data = mem_wd;
            writes.push_back(w);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_csum(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 4 * n; i++) x = x ^ stream[i];
        return x;
    endfunction

    function automatic logic [31:0] model_word(input int k);
        logic [31:0] w = 32'h0;
        for (int i = 0; i < 4; i++) w = w * 256 + 32'(stream[4 * k + i]);
        return w;
    endfunction

    task automatic fill(input int n);
        stream.delete();
        for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
    endtask

    task automatic run_load(input int n, input bit corrupt,
                            input int gap_pct, input int abort_after);
        logic [7:0] cs;
        int         acc;
        int         cyc;
        bit         v;
        bit         exp_we;
        cs = model_csum(n);
        if (corrupt) cs = cs ^ 8'h01;
        writes.delete();
        start      = 1'b1;
        word_count = 16'(n);
        step();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_ready", s_ready, 1);
        chk("start_cpu_rst", cpu_rst, 1);
        acc = 0;
        cyc = 0;
        while (acc < 4 * n && cyc < 40 * n + 100) begin
            if (abort_after >= 0 && acc == abort_after) break;
            v       = ($urandom_range(0, 99) >= gap_pct);
            s_valid = v;
            s_data  = v ? stream[acc] : 8'($urandom);
            step();
            cyc++;
            if (v) acc++;
            exp_we = v && (acc % 4 == 0);
            chk("mem_we", mem_we, 32'(exp_we));
            if (exp_we) begin
                chk("mem_addr", mem_addr, 32'(4 * (acc / 4 - 1)));
                chk("mem_wd", mem_wd, model_word(acc / 4 - 1));
            end
        end
        s_valid = 1'b0;
        if (abort_after >= 0) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_ready", s_ready, 0);
            chk("abort_we", mem_we, 0);
            chk("abort_cpu_rst", cpu_rst, 1);
            step();
            chk("abort_we_idle", mem_we, 0);
            chk("abort_nwrites", writes.size(), 32'(abort_after / 4));
            if (writes.size() > 0) chk("abort_addr0", writes[0].addr, 0);
            return;
        end
        chk("data_bytes", acc, 32'(4 * n));
        chk("check_busy", busy, 1);
        s_valid = 1'b1;
        s_data  = cs;
        step();
        s_valid = 1'b0;
        chk("end_done", done, 32'(!corrupt));
        chk("end_error", error, 32'(corrupt));
        chk("end_cpu_rst", cpu_rst, 32'(corrupt));
        chk("end_busy", busy, 0);
        chk("end_we", mem_we, 0);
        chk("nwrites", writes.size(), 32'(n));
        for (int k = 0; k < n && k < writes.size(); k++) begin
            chk("wr_addr", writes[k].addr, 32'(4 * k));
            chk("wr_data", writes[k].data, model_word(k));
        end
    endtask

    initial begin
        logic [7:0] good[8];
        int         n;
        good = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};

        rst        = 1'b1;
        start      = 1'($urandom);
        word_count = 16'($urandom);
        s_valid    = 1'($urandom);
        s_data     = 8'($urandom);
        step();
        start   = 1'($urandom);
        s_valid = 1'($urandom);
        step();
        chk("rst_ready", s_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wd", mem_wd, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);

        rst        = 1'b0;
        start      = 1'b1;
        word_count = 16'd2;
        s_valid    = 1'b0;
        writes.delete();
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("stall_we", mem_we, 0);
            step();
        end
        chk("stall_busy", busy, 1);
        chk("stall_nwrites", writes.size(), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("stall_rst_busy", busy, 0);

        stream.delete();
        foreach (good[i]) stream.push_back(good[i]);
        run_load(2, 1'b0, 0, -1);
        chk("good_w0", writes.size() > 0 ? writes[0].data : 0, 32'h2008_0005);
        run_load(2, 1'b1, 0, -1);
        run_load(2, 1'b0, 0, -1);

        writes.delete();
        start      = 1'b1;
        word_count = 16'd0;
        step();
        start = 1'b0;
        chk("wc0_error", error, 1);
        chk("wc0_busy", busy, 0);
        chk("wc0_we", mem_we, 0);
        start      = 1'b1;
        word_count = 16'd65;
        step();
        start = 1'b0;
        chk("wc65_error", error, 1);
        chk("wc65_busy", busy, 0);
        step();
        chk("bad_wc_nwrites", writes.size(), 0);

        fill(64);
        run_load(64, 1'b0, 0, -1);
        chk("last_addr", writes.size() == 64 ? writes[63].addr : 0, 32'd252);

        fill(3);
        run_load(3, 1'b0, 0, -1);
        run_load(3, 1'b0, 40, -1);
        run_load(3, 1'b1, 30, -1);

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 8);
            fill(n);
            run_load(n, 1'($urandom), $urandom_range(0, 50), -1);
        end

        fill(2);
        run_load(2, 1'b0, 0, 6);
        run_load(2, 1'b0, 20, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
